detect_collector: RTL and testbench

- Sits directly downstream of the person detector (HOG + SVM); consumes its per-window stream {o_valid, is_person, result, sw_id}.
- Buffers positive windows in a small FIFO for a host/readout engine to drain.
- Keeps a per-frame summary: detection count, best-scoring window, overflow flag.
- Emits a one-cycle frame_done pulse when the last slide window of a frame has been scored.

---
 rtl/detect_collector.sv | 231 +++++++++++++++++++++++
 tb/tb_detect_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_collector.sv
// ---------------------------------------------------------------------------
// detect_collector
//
// Purpose:
//   Sits after the HOG+SVM person detector. Positive windows go into a small
//   FIFO that a host or readout engine drains. Alongside the FIFO, the block
//   keeps a per-frame summary: how many positives were seen, the
//   highest-scoring positive, and whether any positive was dropped because
//   the FIFO was full. A one-cycle frame_done pulse is raised one cycle after
//   the final slide window (sw_id == LAST_SW) of a frame has been scored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_valid             detector result valid
//   is_person           detector decision (qualified by i_valid)
//   result              signed SVM score, Q(FEA_I).(FEA_F)
//   sw_id               slide-window index of this result
//   rd_en               pop request from the reader
//   rd_valid            rd_data valid, one cycle after an accepted pop
//   rd_data             {sw_id, result} of the popped entry
//   empty, full         FIFO status flags
//   frame_done          one-cycle pulse; summary outputs are new this cycle
//   det_count           number of positives in the last completed frame
//   best_id, best_score best positive window of the last completed frame
//   ovf                 a positive was dropped in the last completed frame
//   frame_cnt           completed frame counter, wraps at 2^16
// ---------------------------------------------------------------------------
module detect_collector #(
  parameter int FEA_I   = 4,
  parameter int FEA_F   = 28,
  parameter int SW_W    = 11,
  parameter int LAST_SW = 1679,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic                          is_person,
  input  logic [FEA_I+FEA_F-1:0]        result,
  input  logic [SW_W-1:0]               sw_id,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [SW_W+FEA_I+FEA_F-1:0]   rd_data,
  output logic                          empty,
  output logic                          full,
  output logic                          frame_done,
  output logic [SW_W:0]                 det_count,
  output logic [SW_W-1:0]               best_id,
  output logic [FEA_I+FEA_F-1:0]        best_score,
  output logic                          ovf,
  output logic [15:0]                   frame_cnt
);

  localparam int RW = FEA_I + FEA_F;
  localparam int DW = SW_W + RW;

  // Most negative two's complement score: reported as best_score for a
  // frame without any positive window.
  localparam logic [RW-1:0]   SCORE_MIN = {1'b1, {(RW-1){1'b0}}};
  localparam logic [SW_W-1:0] LAST_ID   = SW_W'(LAST_SW);

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            r_rd_valid;
  logic [DW-1:0]   r_rd_data;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push  = i_valid & is_person;
  assign w_pop   = rd_en & ~w_empty;

  // A full FIFO still accepts a push when a pop frees a slot in the same
  // cycle. When full, write and read address coincide; the registered read
  // below samples the old contents, so the popped entry is not corrupted.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Storage array without reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {sw_id, result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Read port: rd_data holds its last value when no pop is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Running per-frame state
  // -------------------------------------------------------------------------
  logic [SW_W:0]   r_run_cnt;
  logic            r_run_any;
  logic [SW_W-1:0] r_run_best_id;
  logic [RW-1:0]   r_run_best_score;
  logic            r_run_ovf;

  logic [SW_W:0]   w_cnt_next;
  logic            w_better;
  logic            w_any_next;
  logic [SW_W-1:0] w_best_id_next;
  logic [RW-1:0]   w_best_score_next;
  logic            w_ovf_next;
  logic            w_frame_end;

  // Running values including the current window. These feed both the
  // running registers and, on the frame-end window, the summary registers,
  // so the LAST_SW window itself is part of the reported summary.
  assign w_cnt_next = r_run_cnt + {{SW_W{1'b0}}, w_push};

  // The first positive of a frame always loads; later ones must be strictly
  // greater so that on a tie the earlier window is kept.
  assign w_better = w_push &
                    (~r_run_any | ($signed(result) > $signed(r_run_best_score)));

  assign w_any_next        = r_run_any | w_push;
  assign w_best_id_next    = w_better ? sw_id  : r_run_best_id;
  assign w_best_score_next = w_better ? result : r_run_best_score;
  assign w_ovf_next        = r_run_ovf | w_drop;
  assign w_frame_end       = i_valid & (sw_id == LAST_ID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt        <= '0;
      r_run_any        <= 1'b0;
      r_run_best_id    <= '0;
      r_run_best_score <= '0;
      r_run_ovf        <= 1'b0;
    end else if (w_frame_end) begin
      // Clearing here means the frame_done cycle starts a fresh frame, so a
      // result arriving in that cycle is counted toward the new frame.
      r_run_cnt        <= '0;
      r_run_any        <= 1'b0;
      r_run_best_id    <= '0;
      r_run_best_score <= '0;
      r_run_ovf        <= 1'b0;
    end else begin
      if (i_valid) begin
        r_run_cnt        <= w_cnt_next;
        r_run_any        <= w_any_next;
        r_run_best_id    <= w_best_id_next;
        r_run_best_score <= w_best_score_next;
      end
      // Drops only happen with i_valid high, so this is still i_valid gated.
      r_run_ovf <= w_ovf_next;
    end
  end

  // -------------------------------------------------------------------------
  // Frame summary
  // -------------------------------------------------------------------------
  logic            r_frame_done;
  logic [SW_W:0]   r_det_count;
  logic [SW_W-1:0] r_best_id;
  logic [RW-1:0]   r_best_score;
  logic            r_ovf;
  logic [15:0]     r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_det_count  <= '0;
      r_best_id    <= '0;
      r_best_score <= '0;
      r_ovf        <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        r_det_count  <= w_cnt_next;
        r_best_id    <= w_any_next ? w_best_id_next    : '0;
        r_best_score <= w_any_next ? w_best_score_next : SCORE_MIN;
        r_ovf        <= w_ovf_next;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign empty      = w_empty;
  assign full       = w_full;
  assign frame_done = r_frame_done;
  assign det_count  = r_det_count;
  assign best_id    = r_best_id;
  assign best_score = r_best_score;
  assign ovf        = r_ovf;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_detect_collector.sv
// ---------------------------------------------------------------------------
// tb_detect_collector
//
// Directed scenarios plus a randomized phase for detect_collector. The
// reference model keeps the FIFO as a queue and the current frame's
// positives as a list; the frame summary is computed from that list when
// the frame ends.
// ---------------------------------------------------------------------------
module tb_detect_collector;

  localparam int SW_W    = 11;
  localparam int RW      = 32;
  localparam int DW      = SW_W + RW;
  localparam int DEPTH   = 16;
  localparam int LAST_SW = 1679;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic            is_person;
  logic [RW-1:0]   result;
  logic [SW_W-1:0] sw_id;
  logic            rd_en;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            empty;
  logic            full;
  logic            frame_done;
  logic [SW_W:0]   det_count;
  logic [SW_W-1:0] best_id;
  logic [RW-1:0]   best_score;
  logic            ovf;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  detect_collector dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .is_person  (is_person),
    .result     (result),
    .sw_id      (sw_id),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .frame_done (frame_done),
    .det_count  (det_count),
    .best_id    (best_id),
    .best_score (best_score),
    .ovf        (ovf),
    .frame_cnt  (frame_cnt)
  );

  // ------------------------------------------------------------------------
  // Reference model state
  // ------------------------------------------------------------------------
  logic [DW-1:0]   fifo_q [$];
  logic [SW_W-1:0] pos_ids [$];
  logic [RW-1:0]   pos_scores [$];
  logic            m_dropped;

  logic            exp_rd_valid;
  logic [DW-1:0]   exp_rd_data;
  logic            exp_frame_done;
  logic [SW_W:0]   exp_det_count;
  logic [SW_W-1:0] exp_best_id;
  logic [RW-1:0]   exp_best_score;
  logic            exp_ovf;
  logic [15:0]     exp_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    check("rd_valid",   64'(rd_valid),   64'(exp_rd_valid));
    check("rd_data",    64'(rd_data),    64'(exp_rd_data));
    check("empty",      64'(empty),      64'(fifo_q.size() == 0));
    check("full",       64'(full),       64'(fifo_q.size() == DEPTH));
    check("frame_done", 64'(frame_done), 64'(exp_frame_done));
    check("det_count",  64'(det_count),  64'(exp_det_count));
    check("best_id",    64'(best_id),    64'(exp_best_id));
    check("best_score", 64'(best_score), 64'(exp_best_score));
    check("ovf",        64'(ovf),        64'(exp_ovf));
    check("frame_cnt",  64'(frame_cnt),  64'(exp_frame_cnt));
  endtask

  // Frame summary from the list of this frame's positives: count, and the
  // first window holding the maximum signed score.
  task automatic close_frame();
    int bi;
    exp_det_count = (SW_W+1)'(pos_ids.size());
    exp_ovf       = m_dropped;
    if (pos_ids.size() == 0) begin
      exp_best_id    = '0;
      exp_best_score = 32'h8000_0000;
    end else begin
      bi = 0;
      for (int k = 1; k < pos_ids.size(); k++) begin
        if ($signed(pos_scores[k]) > $signed(pos_scores[bi])) bi = k;
      end
      exp_best_id    = pos_ids[bi];
      exp_best_score = pos_scores[bi];
    end
    exp_frame_cnt = exp_frame_cnt + 16'd1;
    pos_ids.delete();
    pos_scores.delete();
    m_dropped = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, then compare outputs
  // one time unit after the rising edge.
  task automatic cyc(input logic v, input logic p, input logic [RW-1:0] res,
                     input logic [SW_W-1:0] id, input logic rd);
    logic          do_pop;
    logic [DW-1:0] popped;
    logic          fe;
    i_valid   = v;
    is_person = p;
    result    = res;
    sw_id     = id;
    rd_en     = rd;
    popped = '0;
    do_pop = rd && (fifo_q.size() > 0);
    if (do_pop) popped = fifo_q.pop_front();
    if (v && p) begin
      pos_ids.push_back(id);
      pos_scores.push_back(res);
      if (fifo_q.size() < DEPTH) fifo_q.push_back({id, res});
      else m_dropped = 1'b1;
    end
    fe = v && (id == SW_W'(LAST_SW));
    @(posedge clk);
    #1;
    exp_rd_valid   = do_pop;
    if (do_pop) exp_rd_data = popped;
    exp_frame_done = fe;
    if (fe) close_frame();
    check_all();
  endtask

  task automatic idle(input logic rd);
    cyc(1'b0, 1'($urandom), $urandom, SW_W'($urandom), rd);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_valid = 1'b0; is_person = 1'b0; result = '0; sw_id = '0; rd_en = 1'b0;
    #1;
    fifo_q.delete(); pos_ids.delete(); pos_scores.delete();
    m_dropped      = 1'b0;
    exp_rd_valid   = 1'b0;
    exp_rd_data    = '0;
    exp_frame_done = 1'b0;
    exp_det_count  = '0;
    exp_best_id    = '0;
    exp_best_score = '0;
    exp_ovf        = 1'b0;
    exp_frame_cnt  = '0;
    check_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    logic [RW-1:0] sc;
    apply_reset();

    // 1: full frame, i_valid every other cycle, three positives.
    for (int i = 0; i <= LAST_SW; i++) begin
      case (i)
        5:       cyc(1'b1, 1'b1, 32'h0100_0000, SW_W'(i), 1'b0);
        100:     cyc(1'b1, 1'b1, 32'h0300_0000, SW_W'(i), 1'b0);
        900:     cyc(1'b1, 1'b1, 32'h0200_0000, SW_W'(i), 1'b0);
        default: cyc(1'b1, 1'b0, $urandom, SW_W'(i), 1'b0);
      endcase
      if (i == LAST_SW) begin
        check("s1_frame_done", 64'(frame_done), 64'd1);
        check("s1_det_count",  64'(det_count),  64'd3);
        check("s1_best_id",    64'(best_id),    64'd100);
        check("s1_best_score", 64'(best_score), 64'h0300_0000);
        check("s1_ovf",        64'(ovf),        64'd0);
        check("s1_frame_cnt",  64'(frame_cnt),  64'd1);
      end
      idle(1'b0);
    end
    for (int k = 0; k < 3; k++) idle(1'b1);
    idle(1'b0);
    check("s1_empty", 64'(empty), 64'd1);

    // 2: 20 back-to-back positives with no reads, then end the frame.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, $urandom, SW_W'(i), 1'b0);
    cyc(1'b1, 1'b0, $urandom, SW_W'(LAST_SW), 1'b0);
    check("s2_det_count", 64'(det_count), 64'd20);
    check("s2_ovf",       64'(ovf),       64'd1);
    check("s2_full",      64'(full),      64'd1);
    for (int k = 0; k < 16; k++) idle(1'b1);
    idle(1'b0);
    check("s2_empty", 64'(empty), 64'd1);

    // 3: push and pop on a full FIFO in the same cycle.
    for (int i = 30; i < 46; i++) cyc(1'b1, 1'b1, $urandom, SW_W'(i), 1'b0);
    cyc(1'b1, 1'b1, $urandom, SW_W'(46), 1'b1);
    check("s3_full_kept", 64'(full),     64'd1);
    check("s3_rd_valid",  64'(rd_valid), 64'd1);
    cyc(1'b1, 1'b0, $urandom, SW_W'(LAST_SW), 1'b0);
    check("s3_det_count", 64'(det_count), 64'd17);
    check("s3_ovf",       64'(ovf),       64'd0);
    for (int k = 0; k < 17; k++) idle(1'b1);

    // 4: frame with no positives and only negative scores.
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 32'h8000_0000 | $urandom, SW_W'(i), 1'b0);
    cyc(1'b1, 1'b0, 32'hF000_0000, SW_W'(LAST_SW), 1'b0);
    check("s4_det_count",  64'(det_count),  64'd0);
    check("s4_best_id",    64'(best_id),    64'd0);
    check("s4_best_score", 64'(best_score), 64'h8000_0000);
    check("s4_empty",      64'(empty),      64'd1);

    // 5: tie on score keeps the earlier window; then read while empty.
    cyc(1'b1, 1'b1, 32'h0080_0000, SW_W'(10), 1'b0);
    cyc(1'b1, 1'b1, 32'h0080_0000, SW_W'(20), 1'b0);
    cyc(1'b1, 1'b0, $urandom, SW_W'(LAST_SW), 1'b0);
    check("s5_best_id", 64'(best_id), 64'd10);
    for (int k = 0; k < 8; k++) idle(1'b1);
    check("s5_rd_valid_empty", 64'(rd_valid), 64'd0);

    // 6: reset in the middle of a frame, then a short frame.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, $urandom, SW_W'(i), 1'b0);
    apply_reset();
    check("s6_empty_after_rst", 64'(empty), 64'd1);
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 7), $urandom, SW_W'(i), 1'b0);
    cyc(1'b1, 1'b0, $urandom, SW_W'(LAST_SW), 1'b0);
    check("s6_det_count", 64'(det_count), 64'd1);
    check("s6_best_id",   64'(best_id),   64'd7);
    check("s6_frame_cnt", 64'(frame_cnt), 64'd1);
    idle(1'b1);
    idle(1'b0);
    check("s6_pop_id", 64'(rd_data[DW-1:RW]), 64'd7);

    // 7: randomized traffic, including ties and frequent frame ends.
    for (int n = 0; n < 6000; n++) begin
      sc = ($urandom_range(0, 3) == 0) ? 32'h0040_0000 : $urandom;
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) == 0),
          sc,
          ($urandom_range(0, 40) == 0) ? SW_W'(LAST_SW) : SW_W'($urandom_range(0, LAST_SW - 1)),
          (n < 3000) ? 1'($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1) == 0));
    end
    for (int k = 0; k < 20; k++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
